// File: rtl/regbank16_16_pkg.sv
// Shared widths, FSM state type and byte-merge helper for the 16x16 register bank.
package regbank16_16_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;
  localparam int NREGS  = 16;
  localparam int BE_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Byte lanes with their enable set take the new word; the rest keep the old one.
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                 input logic [WORD_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    be_merge = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) be_merge[b*8 +: 8] = new_w[b*8 +: 8];
    end
  endfunction

endpackage

// File: rtl/regbank16_16_wdec.sv
// One-hot write decoder: selects the destination register for an accepted write.
module regbank16_16_wdec
  import regbank16_16_pkg::*;
#(
  parameter int ZERO_R0 = 0
) (
  input  logic             accept_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [NREGS-1:0] hit_o
);

  always_comb begin
    hit_o = '0;
    if (accept_i) hit_o[sel_i] = 1'b1;
    // A read-only R0 still completes the handshake; only the load is suppressed.
    if (ZERO_R0 != 0) hit_o[0] = 1'b0;
  end

endmodule

// File: rtl/regbank16_16.sv
// 16-word x 16-bit register bank with byte-enabled write port and sequenced clear-all sweep.
//   state | meaning
//   IDLE  | writes accepted, waiting for clr_req
//   CLEAR | one register reset per cycle, writes stalled
module regbank16_16
  import regbank16_16_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VAL = 16'h0000,
  parameter int                ZERO_R0   = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [BE_W-1:0]   wr_be_i,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic [WORD_W-1:0] r0_o,
  output logic [WORD_W-1:0] r1_o,
  output logic [WORD_W-1:0] r2_o,
  output logic [WORD_W-1:0] r3_o,
  output logic [WORD_W-1:0] r4_o,
  output logic [WORD_W-1:0] r5_o,
  output logic [WORD_W-1:0] r6_o,
  output logic [WORD_W-1:0] r7_o,
  output logic [WORD_W-1:0] r8_o,
  output logic [WORD_W-1:0] r9_o,
  output logic [WORD_W-1:0] r10_o,
  output logic [WORD_W-1:0] r11_o,
  output logic [WORD_W-1:0] r12_o,
  output logic [WORD_W-1:0] r13_o,
  output logic [WORD_W-1:0] r14_o,
  output logic [WORD_W-1:0] r15_o
);

  state_e                        state_q, state_d;
  logic [SEL_W-1:0]              clr_cnt_q, clr_cnt_d;
  logic                          clr_done_q, clr_done_d;
  logic [NREGS-1:0][WORD_W-1:0]  regs_q, regs_d;
  logic                          wr_accept;
  logic [NREGS-1:0]              wr_hit;

  assign wr_ready_o = (state_q == IDLE);
  assign wr_accept  = wr_valid_i & wr_ready_o;

  regbank16_16_wdec #(
    .ZERO_R0 (ZERO_R0)
  ) u_wdec (
    .accept_i (wr_accept),
    .sel_i    (wr_sel_i),
    .hit_o    (wr_hit)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == SEL_W'(NREGS - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes only land in IDLE and the sweep only runs in CLEAR, so the two never collide.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_hit[i]) regs_d[i] = be_merge(regs_q[i], wr_data_i, wr_be_i);
    end
    if (state_q == CLEAR) regs_d[clr_cnt_q] = RESET_VAL;
    if (ZERO_R0 != 0) regs_d[0] = RESET_VAL;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      regs_q     <= {NREGS{RESET_VAL}};
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
      regs_q     <= regs_d;
    end
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_done_o = clr_done_q;

  assign r0_o  = regs_q[0];
  assign r1_o  = regs_q[1];
  assign r2_o  = regs_q[2];
  assign r3_o  = regs_q[3];
  assign r4_o  = regs_q[4];
  assign r5_o  = regs_q[5];
  assign r6_o  = regs_q[6];
  assign r7_o  = regs_q[7];
  assign r8_o  = regs_q[8];
  assign r9_o  = regs_q[9];
  assign r10_o = regs_q[10];
  assign r11_o = regs_q[11];
  assign r12_o = regs_q[12];
  assign r13_o = regs_q[13];
  assign r14_o = regs_q[14];
  assign r15_o = regs_q[15];

endmodule
